fifo_write_arbiter: RTL and testbench

Shares the single write port of the team's pulse-driven FIFO between two independent producers, for example the UART RX path and the local config/status path in the RF transceiver. The block arbitrates requests, latches the winning word and generates a clean one-cycle `fifo_write_ins` strobe followed by a low recovery cycle, because the FIFO advances on the strobe's rising edge. It never issues a write while the FIFO reports full, and it acknowledges each accepted word to its producer with a one-cycle pulse.

---
 rtl/fifo_write_arbiter_if.sv | 26 ++
 rtl/fifo_write_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Bundle between fifo_write_arbiter and its two producers plus the FIFO write port.
// master: the producers/FIFO side; slave: the arbiter itself.
interface fifo_write_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ack;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ack;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_write_ins;
    logic             busy;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, fifo_full,
        input  req0_ack, req1_ack, fifo_data_out, fifo_write_ins, busy
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, fifo_full,
        output req0_ack, req1_ack, fifo_data_out, fifo_write_ins, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares the pulse-driven FIFO write port between two producers.
// Each accepted word produces a 3-clock cycle: IDLE decision, STROBE (write + ack),
// RECOVER (strobe low). All outputs come straight from flops.
// Optional feature: define FIFO_ARB_RR_EN for round-robin arbitration; without it,
// producer 0 has fixed priority.
module fifo_write_arbiter #(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    fifo_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             grant_en;
    logic             winner;
    logic             gnt_idx;
    logic             gnt_idx_next;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_next;
    logic             write_q;
    logic             write_next;
    logic             ack0_q;
    logic             ack0_next;
    logic             ack1_q;
    logic             ack1_next;
    logic             busy_q;
    logic             busy_next;
`ifdef FIFO_ARB_RR_EN
    logic             last_gnt;
`endif

    // Arbitration: a grant happens only in IDLE with a request pending and room in the FIFO
    always_comb begin
        grant_en = (state == IDLE) && (bus.req0_valid || bus.req1_valid) && !bus.fifo_full;
`ifdef FIFO_ARB_RR_EN
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_gnt;
        end else begin
            winner = ~bus.req0_valid;
        end
`else
        winner = ~bus.req0_valid;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: STROBE and RECOVER each last exactly one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_en) state_next = STROBE;
            STROBE:  state_next = RECOVER;
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, derived from the next state
    always_comb begin
        gnt_idx_next = gnt_idx;
        data_next    = data_q;
        if (grant_en) begin
            gnt_idx_next = winner;
            data_next    = winner ? bus.req1_data : bus.req0_data;
        end
        write_next = (state_next == STROBE);
        ack0_next  = write_next && !gnt_idx_next;
        ack1_next  = write_next && gnt_idx_next;
        busy_next  = (state_next != IDLE);
    end

    // Output and grant registers; the word only moves on the IDLE->STROBE edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_idx <= 1'b0;
            data_q  <= '0;
            write_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            gnt_idx <= gnt_idx_next;
            data_q  <= data_next;
            write_q <= write_next;
            ack0_q  <= ack0_next;
            ack1_q  <= ack1_next;
            busy_q  <= busy_next;
        end
    end

`ifdef FIFO_ARB_RR_EN
    // Grant history: reset to 1 so producer 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (state == STROBE) begin
            last_gnt <= gnt_idx;
        end
    end
`endif

    assign bus.fifo_data_out  = data_q;
    assign bus.fifo_write_ins = write_q;
    assign bus.req0_ack       = ack0_q;
    assign bus.req1_ack       = ack1_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: vector table plus hand-written multi-cycle
// sequences, with a scoreboard queue of expected writes checked on every strobe.
module tb_fifo_write_arbiter;
    logic clk;
    logic rst_n;
    logic full_force;
    logic model_en;
    logic fifo_rd;
    int   fifo_cnt;
    int   cyc;
    int   checks;
    int   errors;
    int   strobe_cnt;
    int   last_strobe_cyc;
    logic prev_wi;

    typedef struct packed {
        logic       idx;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        string      name;
        logic       r0v;
        logic [7:0] r0d;
        logic       r1v;
        logic [7:0] r1d;
        logic       exp_idx;
        logic [7:0] exp_data;
    } vec_t;
    vec_t vecs[5];

    fifo_write_arbiter_if #(.WIDTH(8)) bus ();

    fifo_write_arbiter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Simple 32-deep FIFO occupancy model used for the fill test
    assign bus.fifo_full = model_en ? (fifo_cnt >= 32) : full_force;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fifo_cnt <= 0;
        else fifo_cnt <= fifo_cnt + (bus.fifo_write_ins ? 1 : 0) - (fifo_rd ? 1 : 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic idx, input logic [7:0] d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe consumes one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (bus.fifo_write_ins) begin
            check("strobe_gap", 32'(prev_wi), 32'd0);
            strobe_cnt++;
            last_strobe_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: data 0x%0h written, no write expected", bus.fifo_data_out);
            end else begin
                e = exp_q.pop_front();
                check("strobe_data", 32'(bus.fifo_data_out), 32'(e.data));
                check("strobe_ack0", 32'(bus.req0_ack), 32'(!e.idx));
                check("strobe_ack1", 32'(bus.req1_ack), 32'(e.idx));
                check("strobe_busy", 32'(bus.busy), 32'd1);
            end
        end else if (bus.req0_ack || bus.req1_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_without_strobe: ack0=%0b ack1=%0b, strobe=0", bus.req0_ack, bus.req1_ack);
        end
        prev_wi = bus.fifo_write_ins;
    end

    task automatic wait_strobe(input string name, input int budget);
        int target;
        int n;
        target = strobe_cnt + 1;
        n = 0;
        while (strobe_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (strobe_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s: no strobe within %0d cycles, required one", name, budget);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        full_force = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c0;
        int t_prev;
        logic [1:0] rr_idx;

        checks = 0; errors = 0; strobe_cnt = 0; last_strobe_cyc = 0; cyc = 0;
        prev_wi = 1'b0; model_en = 1'b0; fifo_rd = 1'b0; full_force = 1'b0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00;

        vecs[0] = '{"vec_only0",  1'b1, 8'h3C, 1'b0, 8'h99, 1'b0, 8'h3C};
        vecs[1] = '{"vec_only1",  1'b0, 8'h99, 1'b1, 8'hC3, 1'b1, 8'hC3};
        vecs[2] = '{"vec_tie",    1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 8'h01};
        vecs[3] = '{"vec_only1b", 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'hFF};
        vecs[4] = '{"vec_only0b", 1'b1, 8'h00, 1'b0, 8'hAA, 1'b0, 8'h00};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_write_ins", 32'(bus.fifo_write_ins), 32'd0);
        check("rst_ack0", 32'(bus.req0_ack), 32'd0);
        check("rst_ack1", 32'(bus.req1_ack), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data", 32'(bus.fifo_data_out), 32'd0);
        do_reset();

        // Basic single write, cycle by cycle
        bus.req0_valid = 1'b1;
        bus.req0_data = 8'hA5;
        push_exp(1'b0, 8'hA5);
        @(negedge clk); #1;
        check("t1_decide_write", 32'(bus.fifo_write_ins), 32'd0);
        check("t1_decide_busy", 32'(bus.busy), 32'd0);
        @(negedge clk); #1;
        check("t1_strobe_write", 32'(bus.fifo_write_ins), 32'd1);
        check("t1_strobe_ack0", 32'(bus.req0_ack), 32'd1);
        check("t1_strobe_data", 32'(bus.fifo_data_out), 32'hA5);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req0_data = 8'h00;
        @(negedge clk); #1;
        check("t1_recover_write", 32'(bus.fifo_write_ins), 32'd0);
        check("t1_recover_ack0", 32'(bus.req0_ack), 32'd0);
        check("t1_recover_busy", 32'(bus.busy), 32'd1);
        check("t1_recover_data", 32'(bus.fifo_data_out), 32'hA5);
        @(negedge clk); #1;
        check("t1_idle_busy", 32'(bus.busy), 32'd0);
        check("t1_idle_data", 32'(bus.fifo_data_out), 32'hA5);

        // Vector table: one request pattern per entry, from a fresh reset
        for (int i = 0; i < 5; i++) begin
            do_reset();
            c0 = cyc;
            bus.req0_valid = vecs[i].r0v; bus.req0_data = vecs[i].r0d;
            bus.req1_valid = vecs[i].r1v; bus.req1_data = vecs[i].r1d;
            push_exp(vecs[i].exp_idx, vecs[i].exp_data);
            wait_strobe(vecs[i].name, 4);
            check({vecs[i].name, "_latency"}, 32'(last_strobe_cyc - c0), 32'd1);
            @(posedge clk); #1;
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            idle_cycles(3);
        end

        // Both producers requesting continuously
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_data = 8'h11;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h22;
        for (int k = 0; k < 4; k++) begin
            rr_idx = 2'(k);
`ifdef FIFO_ARB_RR_EN
            push_exp(rr_idx[0], rr_idx[0] ? 8'h22 : 8'h11);
`else
            push_exp(1'b0, 8'h11);
`endif
        end
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_strobe("both_strobe", 5);
            if (k > 0) check("both_spacing", 32'(last_strobe_cyc - t_prev), 32'd3);
            t_prev = last_strobe_cyc;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        idle_cycles(5);

        // FIFO full blocks producer 1, then release
        do_reset();
        full_force = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h5A;
        push_exp(1'b1, 8'h5A);
        base = strobe_cnt;
        idle_cycles(10);
        check("full_no_strobe", 32'(strobe_cnt - base), 32'd0);
        @(posedge clk); #1;
        full_force = 1'b0;
        wait_strobe("full_release", 2);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        idle_cycles(3);

        // Full rising during STROBE does not abort the write
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_data = 8'h77;
        push_exp(1'b0, 8'h77);
        wait_strobe("fullmid_first", 4);
        full_force = 1'b1;
        @(posedge clk); #1;
        bus.req0_data = 8'h78;
        @(negedge clk); #1;
        check("fullmid_recover_write", 32'(bus.fifo_write_ins), 32'd0);
        base = strobe_cnt;
        idle_cycles(6);
        check("fullmid_held", 32'(strobe_cnt - base), 32'd0);
        check("fullmid_held_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        full_force = 1'b0;
        push_exp(1'b0, 8'h78);
        wait_strobe("fullmid_second", 3);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        idle_cycles(3);

        // Reset pulse in the middle of a strobe
        do_reset();
        bus.req1_valid = 1'b1; bus.req1_data = 8'h9C;
        push_exp(1'b1, 8'h9C);
        wait_strobe("rstmid_first", 4);
        rst_n = 1'b0;
        #1;
        check("rstmid_write", 32'(bus.fifo_write_ins), 32'd0);
        check("rstmid_ack1", 32'(bus.req1_ack), 32'd0);
        check("rstmid_data", 32'(bus.fifo_data_out), 32'd0);
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        base = strobe_cnt;
        push_exp(1'b1, 8'h9C);
        wait_strobe("rstmid_retry", 4);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        idle_cycles(5);
        check("rstmid_one_strobe", 32'(strobe_cnt - base), 32'd1);

        // 33 words into a 32-deep FIFO with no reads
        do_reset();
        model_en = 1'b1;
        base = strobe_cnt;
        bus.req0_valid = 1'b1;
        for (int w = 0; w < 32; w++) begin
            bus.req0_data = 8'(8'h40 + w);
            push_exp(1'b0, 8'(8'h40 + w));
            wait_strobe("fill_word", 6);
            @(posedge clk); #1;
        end
        bus.req0_data = 8'h60;
        idle_cycles(10);
        check("fill_32_strobes", 32'(strobe_cnt - base), 32'd32);
        check("fill_count", 32'(fifo_cnt), 32'd32);
        check("fill_held_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        fifo_rd = 1'b1;
        push_exp(1'b0, 8'h60);
        @(posedge clk); #1;
        fifo_rd = 1'b0;
        wait_strobe("fill_33rd", 6);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        idle_cycles(4);
        check("fill_33_strobes", 32'(strobe_cnt - base), 32'd33);
        check("fill_count_end", 32'(fifo_cnt), 32'd32);
        model_en = 1'b0;

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
